// File: rtl/rtp_collect_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rtp_collect_pkg
//  Description : Shared types, default widths and width helpers for the
//                ray-tracing result collector.
//  Revision    : 1.0  initial release
// ============================================================================
package rtp_collect_pkg;

    localparam int c_def_num_ch     = 2;
    localparam int c_def_id_w       = 32;
    localparam int c_def_t_w        = 32;
    localparam int c_def_fifo_depth = 8;
    localparam int c_def_cnt_w      = 64;

    // Channel index width; a single channel still gets a 1-bit index.
    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Occupancy width: must be able to represent DEPTH itself.
    function automatic int lvl_width(input int d);
        return $clog2(d) + 1;
    endfunction

    // Result record at the default widths.
    typedef struct packed {
        logic [c_def_id_w-1:0]               ray_id;
        logic [c_def_t_w-1:0]                hitT;
        logic [ch_width(c_def_num_ch)-1:0]   ch;
    } rtp_result_t;

endpackage
`default_nettype wire

// File: rtl/rtp_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rtp_rr_arbiter
//  Description : Combinational round-robin arbiter. Grants the first
//                requester at or above i_ptr, wrapping NUM_CH-1 -> 0.
//  Ports       : i_req   request vector
//                i_ptr   highest-priority channel index
//                i_en    arbitration enable (no grant when low)
//                o_grant one-hot grant (zero when nothing granted)
//                o_idx   index of granted channel
//                o_any   a grant was issued
//  Revision    : 1.0  initial release
// ============================================================================
module rtp_rr_arbiter
    import rtp_collect_pkg::*;
#(
    parameter int NUM_CH = 2
) (
    input  logic [NUM_CH-1:0]           i_req,
    input  logic [ch_width(NUM_CH)-1:0] i_ptr,
    input  logic                        i_en,
    output logic [NUM_CH-1:0]           o_grant,
    output logic [ch_width(NUM_CH)-1:0] o_idx,
    output logic                        o_any
);

    localparam int c_ch_w = ch_width(NUM_CH);

    int w_j;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        w_j     = 0;
        if (i_en) begin
            for (int k = 0; k < NUM_CH; k++) begin
                w_j = int'(i_ptr) + k;
                if (w_j >= NUM_CH) begin
                    w_j = w_j - NUM_CH;
                end
                if (!o_any && i_req[w_j]) begin
                    o_any        = 1'b1;
                    o_grant[w_j] = 1'b1;
                    o_idx        = c_ch_w'(w_j);
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/rtp_result_collector.sv
`default_nettype none
// ============================================================================
//  Module      : rtp_result_collector
//  Description : Collects per-ray results from NUM_CH channels, round-robin
//                arbitrates them into a show-ahead FIFO, tracks channel
//                completion and a frozen total-cycle counter.
//  Ports       : clock/reset        clock, synchronous active-high reset
//                in_valid/in_ready  per-channel handshake (ready one-hot)
//                in_ray_id/in_hitT  packed per-channel payload
//                in_finish          per-channel last-result pulse
//                out_*              FIFO head stream (valid/ready)
//                all_finish         sticky: all done and drained
//                cycle_count        cycles from reset release to all_finish
//                fifo_level         current FIFO occupancy
//  Option      : RTP_COLLECT_PERF_EN adds perf_accept / perf_stall counters.
//  Revision    : 1.0  initial release
// ============================================================================
module rtp_result_collector
    import rtp_collect_pkg::*;
#(
    parameter int NUM_CH     = c_def_num_ch,
    parameter int ID_W       = c_def_id_w,
    parameter int T_W        = c_def_t_w,
    parameter int FIFO_DEPTH = c_def_fifo_depth,
    parameter int CNT_W      = c_def_cnt_w
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic [NUM_CH-1:0]                 in_valid,
    output logic [NUM_CH-1:0]                 in_ready,
    input  logic [NUM_CH*ID_W-1:0]            in_ray_id,
    input  logic [NUM_CH*T_W-1:0]             in_hitT,
    input  logic [NUM_CH-1:0]                 in_finish,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [ID_W-1:0]                   out_ray_id,
    output logic [T_W-1:0]                    out_hitT,
    output logic [ch_width(NUM_CH)-1:0]       out_ch,
    output logic                              all_finish,
    output logic [CNT_W-1:0]                  cycle_count,
    output logic [lvl_width(FIFO_DEPTH)-1:0]  fifo_level
`ifdef RTP_COLLECT_PERF_EN
    ,
    output logic [NUM_CH*CNT_W-1:0]           perf_accept,
    output logic [CNT_W-1:0]                  perf_stall
`endif
);

    localparam int c_ch_w  = ch_width(NUM_CH);
    localparam int c_lvl_w = lvl_width(FIFO_DEPTH);
    localparam int c_aw    = $clog2(FIFO_DEPTH);

    typedef struct packed {
        logic [ID_W-1:0]   ray_id;
        logic [T_W-1:0]    hitT;
        logic [c_ch_w-1:0] ch;
    } entry_t;

    entry_t              r_mem [FIFO_DEPTH];
    logic [c_aw-1:0]     r_wptr;
    logic [c_aw-1:0]     r_rptr;
    logic [c_lvl_w-1:0]  r_level;
    logic [c_ch_w-1:0]   r_rr_ptr;
    logic [NUM_CH-1:0]   r_fin;
    logic                r_all_finish;
    logic [CNT_W-1:0]    r_cycle_count;

    logic                w_full;
    logic                w_wr;
    logic                w_rd;
    logic [NUM_CH-1:0]   w_grant;
    logic [c_ch_w-1:0]   w_gidx;
    entry_t              w_wr_entry;
    entry_t              w_head;

    // Full comes from the registered level so a same-cycle read never
    // opens a write slot; in_ready is therefore independent of out_ready.
    assign w_full = (r_level == c_lvl_w'(FIFO_DEPTH));
    assign w_rd   = (r_level != '0) && out_ready;

    rtp_rr_arbiter #(
        .NUM_CH (NUM_CH)
    ) u_arb (
        .i_req   (in_valid),
        .i_ptr   (r_rr_ptr),
        .i_en    (!w_full),
        .o_grant (w_grant),
        .o_idx   (w_gidx),
        .o_any   (w_wr)
    );

    assign in_ready = w_grant;

    always_comb begin
        w_wr_entry.ray_id = in_ray_id[int'(w_gidx)*ID_W +: ID_W];
        w_wr_entry.hitT   = in_hitT[int'(w_gidx)*T_W +: T_W];
        w_wr_entry.ch     = w_gidx;
    end

    assign w_head      = r_mem[r_rptr];
    assign out_valid   = (r_level != '0);
    assign out_ray_id  = w_head.ray_id;
    assign out_hitT    = w_head.hitT;
    assign out_ch      = w_head.ch;
    assign fifo_level  = r_level;
    assign all_finish  = r_all_finish;
    assign cycle_count = r_cycle_count;

    // Storage carries no reset; validity is tracked by r_level alone.
    always_ff @(posedge clock) begin
        if (w_wr) begin
            r_mem[r_wptr] <= w_wr_entry;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wptr        <= '0;
            r_rptr        <= '0;
            r_level       <= '0;
            r_rr_ptr      <= '0;
            r_fin         <= '0;
            r_all_finish  <= 1'b0;
            r_cycle_count <= '0;
        end else begin
            if (w_wr) begin
                r_wptr <= r_wptr + 1'b1;
                if (int'(w_gidx) == NUM_CH - 1) begin
                    r_rr_ptr <= '0;
                end else begin
                    r_rr_ptr <= w_gidx + 1'b1;
                end
            end
            if (w_rd) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_wr, w_rd})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase

            r_fin <= r_fin | in_finish;

            if ((&r_fin) && (r_level == '0) && (in_valid == '0) && !w_wr) begin
                r_all_finish <= 1'b1;
            end

            if (!r_all_finish && (r_cycle_count != '1)) begin
                r_cycle_count <= r_cycle_count + 1'b1;
            end
        end
    end

`ifdef RTP_COLLECT_PERF_EN
    logic [CNT_W-1:0] r_perf_accept [NUM_CH];
    logic [CNT_W-1:0] r_perf_stall;

    // Counters share the cycle_count freeze so all reports cover one window.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_perf_accept[i] <= '0;
            end
            r_perf_stall <= '0;
        end else if (!r_all_finish) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (w_grant[i] && (r_perf_accept[i] != '1)) begin
                    r_perf_accept[i] <= r_perf_accept[i] + 1'b1;
                end
            end
            if ((|in_valid) && w_full && (r_perf_stall != '1)) begin
                r_perf_stall <= r_perf_stall + 1'b1;
            end
        end
    end

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_perf_out
        assign perf_accept[gi*CNT_W +: CNT_W] = r_perf_accept[gi];
    end
    assign perf_stall = r_perf_stall;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rtp_result_collector.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rtp_result_collector
//  Description : Directed self-checking bench for rtp_result_collector.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_rtp_result_collector;

    localparam int NUM_CH     = 2;
    localparam int ID_W       = 32;
    localparam int T_W        = 32;
    localparam int FIFO_DEPTH = 8;
    localparam int CNT_W      = 64;

    logic                     clock = 1'b0;
    logic                     reset = 1'b1;
    logic [NUM_CH-1:0]        in_valid;
    logic [NUM_CH-1:0]        in_ready;
    logic [NUM_CH*ID_W-1:0]   in_ray_id;
    logic [NUM_CH*T_W-1:0]    in_hitT;
    logic [NUM_CH-1:0]        in_finish;
    logic                     out_valid;
    logic                     out_ready;
    logic [ID_W-1:0]          out_ray_id;
    logic [T_W-1:0]           out_hitT;
    logic [0:0]               out_ch;
    logic                     all_finish;
    logic [CNT_W-1:0]         cycle_count;
    logic [3:0]               fifo_level;
`ifdef RTP_COLLECT_PERF_EN
    logic [NUM_CH*CNT_W-1:0]  perf_accept;
    logic [CNT_W-1:0]         perf_stall;
`endif

    rtp_result_collector #(
        .NUM_CH     (NUM_CH),
        .ID_W       (ID_W),
        .T_W        (T_W),
        .FIFO_DEPTH (FIFO_DEPTH),
        .CNT_W      (CNT_W)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_ray_id   (in_ray_id),
        .in_hitT     (in_hitT),
        .in_finish   (in_finish),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_ray_id  (out_ray_id),
        .out_hitT    (out_hitT),
        .out_ch      (out_ch),
        .all_finish  (all_finish),
        .cycle_count (cycle_count),
        .fifo_level  (fifo_level)
`ifdef RTP_COLLECT_PERF_EN
        ,
        .perf_accept (perf_accept),
        .perf_stall  (perf_stall)
`endif
    );

    always #5 clock = ~clock;

    int     n_pass   = 0;
    int     n_fail   = 0;
    int     n_checks = 0;
    int     n_cyc    = 0;
    longint frozen   = 0;

    function automatic logic [31:0] hit_of(input logic [31:0] id);
        return id ^ 32'h3F80_0000;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock edge, then step just past it; counts unreset edges.
    task automatic tick();
        if (!reset) n_cyc++;
        @(posedge clock);
        #1;
    endtask

    task automatic put(input int c, input logic [31:0] id);
        in_ray_id[c*32 +: 32] = id;
        in_hitT[c*32 +: 32]   = hit_of(id);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  exp_rdy [7];
        logic [31:0] exp_id;
        int cnt0;
        int cnt1;

        exp_rdy = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b00};
        in_valid  = '0;
        in_finish = '0;
        in_ray_id = '0;
        in_hitT   = '0;
        out_ready = 1'b0;

        // ---- Reset state ----
        tick();
        tick();
        chk("rst_out_valid",   64'(out_valid),   64'(0));
        chk("rst_in_ready",    64'(in_ready),    64'(0));
        chk("rst_fifo_level",  64'(fifo_level),  64'(0));
        chk("rst_all_finish",  64'(all_finish),  64'(0));
        chk("rst_cycle_count", 64'(cycle_count), 64'(0));

        // ---- Idle 20 cycles ----
        reset = 1'b0;
        n_cyc = 0;
        repeat (20) tick();
        chk("idle_cycle_count", 64'(cycle_count), 64'(20));
        chk("idle_out_valid",   64'(out_valid),   64'(0));
        chk("idle_all_finish",  64'(all_finish),  64'(0));

        // ---- Two channels, 3 results each, round-robin ----
        out_ready = 1'b1;
        cnt0 = 0;
        cnt1 = 0;
        for (int k = 0; k < 7; k++) begin
            in_valid = {(cnt1 < 3), (cnt0 < 3)};
            put(0, 32'h100 + 32'(cnt0));
            put(1, 32'h200 + 32'(cnt1));
            #1;
            chk("rr_ready", 64'(in_ready), 64'(exp_rdy[k]));
            if (k == 0) begin
                chk("rr_first_empty", 64'(out_valid), 64'(0));
            end else begin
                exp_id = (((k - 1) % 2) == 1 ? 32'h200 : 32'h100) + 32'((k - 1) / 2);
                chk("rr_out_valid", 64'(out_valid),  64'(1));
                chk("rr_out_ch",    64'(out_ch),     64'((k - 1) % 2));
                chk("rr_out_id",    64'(out_ray_id), 64'(exp_id));
                chk("rr_out_hit",   64'(out_hitT),   64'(hit_of(exp_id)));
            end
            tick();
            if (exp_rdy[k][0]) cnt0++;
            if (exp_rdy[k][1]) cnt1++;
        end
        in_valid = '0;
        chk("rr_drained", 64'(fifo_level), 64'(0));

        // ---- Fill to full with ch0, out_ready low ----
        out_ready = 1'b0;
        cnt0 = 0;
        in_valid = 2'b01;
        for (int k = 0; k < 10; k++) begin
            put(0, 32'(cnt0));
            #1;
            chk("fill_ready", 64'(in_ready), 64'((k < 8) ? 1 : 0));
            tick();
            if (k < 8) cnt0++;
        end
        chk("fill_level", 64'(fifo_level), 64'(8));
        chk("fill_ready_full", 64'(in_ready), 64'(0));

        // ---- Full with read and valid together: read only ----
        out_ready = 1'b1;
        #1;
        chk("full_no_write", 64'(in_ready),   64'(0));
        chk("full_head_id",  64'(out_ray_id), 64'(0));
        tick();
        chk("full_read_level", 64'(fifo_level), 64'(7));
        for (int j = 0; j < 9; j++) begin
            in_valid = (j < 2) ? 2'b01 : 2'b00;
            put(0, 32'(8 + j));
            #1;
            chk("drain_ready", 64'(in_ready),   64'((j < 2) ? 1 : 0));
            chk("drain_valid", 64'(out_valid),  64'(1));
            chk("drain_id",    64'(out_ray_id), 64'(1 + j));
            chk("drain_hit",   64'(out_hitT),   64'(hit_of(32'(1 + j))));
            tick();
            chk("drain_level", 64'(fifo_level), 64'((j < 2) ? 7 : (8 - j)));
        end
        chk("drain_empty", 64'(out_valid), 64'(0));

        // ---- Finish with 2 results still queued ----
        out_ready = 1'b0;
        in_valid  = 2'b01;
        put(0, 32'h50);
        tick();
        put(0, 32'h51);
        tick();
        in_valid  = 2'b00;
        in_finish = 2'b11;
        tick();
        in_finish = 2'b00;
        chk("fin_level", 64'(fifo_level), 64'(2));
        chk("fin_not_yet", 64'(all_finish), 64'(0));
        tick();
        chk("fin_hold_queued", 64'(all_finish), 64'(0));
        out_ready = 1'b1;
        #1;
        chk("fin_head0", 64'(out_ray_id), 64'(32'h50));
        tick();
        chk("fin_head1", 64'(out_ray_id), 64'(32'h51));
        tick();
        chk("fin_last_read_level", 64'(fifo_level), 64'(0));
        chk("fin_last_read_af",    64'(all_finish), 64'(0));
        tick();
        chk("fin_all_finish", 64'(all_finish), 64'(1));
        frozen = longint'(n_cyc);
        chk("fin_cycle_count", 64'(cycle_count), 64'(frozen));
        repeat (50) tick();
        chk("fin_frozen_count", 64'(cycle_count), 64'(frozen));
        chk("fin_sticky",       64'(all_finish),  64'(1));

        // ---- Reset with 5 entries queued ----
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_cyc = 0;
        out_ready = 1'b0;
        in_valid  = 2'b11;
        for (int k = 0; k < 5; k++) begin
            put(0, 32'h300 + 32'(k));
            put(1, 32'h400 + 32'(k));
            tick();
        end
        in_valid = 2'b00;
        chk("q5_level", 64'(fifo_level), 64'(5));
        reset = 1'b1;
        tick();
        chk("mrst_level",       64'(fifo_level),  64'(0));
        chk("mrst_out_valid",   64'(out_valid),   64'(0));
        chk("mrst_all_finish",  64'(all_finish),  64'(0));
        chk("mrst_cycle_count", 64'(cycle_count), 64'(0));
        reset = 1'b0;
        in_valid = 2'b11;
        put(0, 32'h600);
        put(1, 32'h700);
        #1;
        chk("mrst_rr_tie", 64'(in_ready), 64'(2'b01));
        tick();
        in_valid = 2'b00;
        chk("mrst_out_valid1", 64'(out_valid),  64'(1));
        chk("mrst_out_ch",     64'(out_ch),     64'(0));
        chk("mrst_out_id",     64'(out_ray_id), 64'(32'h600));
        chk("mrst_level1",     64'(fifo_level), 64'(1));
        out_ready = 1'b1;
        tick();
        tick();
        tick();
        chk("mrst_fin_cleared", 64'(all_finish), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
